// File: rtl/seg7_dec_if.sv
// seg7_dec_if: bundles the digit-pair inputs, the decoded-result handshake
// and the error/status outputs of seg7_dec.
//
// Signals:
//   Seg7In_upper[6:0] tens-digit pattern, active-low, bit6=a ... bit0=g
//   Seg7In_lower[6:0] ones-digit pattern, same encoding
//   out_ready         consumer accepts Bit6Out this edge
//   Bit6Out[5:0]      decoded value 0..63
//   out_valid         Bit6Out holds an unaccepted result
//   err_valid         one-cycle decode-error pulse
//   err_code[1:0]     01 bad upper, 10 bad lower, 11 value>63 (with err_valid)
//   overrun           sticky: a good decode was deferred by a pending result
//
// Handshake: a result transfers on a rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// Bit6Out is held stable. out_valid never drops without a transfer.
//
// Modports: slave = the decoder, master = the pattern source / consumer.
interface seg7_dec_if;
  logic [6:0] Seg7In_upper;
  logic [6:0] Seg7In_lower;
  logic       out_ready;
  logic [5:0] Bit6Out;
  logic       out_valid;
  logic       err_valid;
  logic [1:0] err_code;
  logic       overrun;

  modport slave (
    input  Seg7In_upper,
    input  Seg7In_lower,
    input  out_ready,
    output Bit6Out,
    output out_valid,
    output err_valid,
    output err_code,
    output overrun
  );

  modport master (
    output Seg7In_upper,
    output Seg7In_lower,
    output out_ready,
    input  Bit6Out,
    input  out_valid,
    input  err_valid,
    input  err_code,
    input  overrun
  );
endinterface

// File: rtl/seg7_dec.sv
// seg7_dec: two-digit active-low 7-segment decoder.
// Samples the tens/ones glyph pair every edge, waits until the same pair has
// been seen STABLE_CYCLES times in a row, validates both glyphs, converts the
// decimal pair to a 6-bit value and presents it on a valid/ready output.
// A stable pair is reported once; it is reported again only after the input
// has moved to another stable pair and come back.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_dec_if.slave (pattern inputs, result handshake, error/status)
module seg7_dec #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_dec_if.slave   bus
);

  localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [13:0]   PAT_ZERO = {7'b0000001, 7'b0000001};

  // Returns {valid, digit}; anything outside the ten legal glyphs is invalid.
  function automatic logic [4:0] glyph_to_digit(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'b0000001: r = 5'b1_0000;
      7'b1001111: r = 5'b1_0001;
      7'b0010010: r = 5'b1_0010;
      7'b0000110: r = 5'b1_0011;
      7'b1001100: r = 5'b1_0100;
      7'b0100100: r = 5'b1_0101;
      7'b0100000: r = 5'b1_0110;
      7'b0001111: r = 5'b1_0111;
      7'b0000000: r = 5'b1_1000;
      7'b0001100: r = 5'b1_1001;
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [13:0]   in_pat;
  logic [13:0]   pat_q, pat_d;
  logic [13:0]   last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit6_q, bit6_d;
  logic          valid_q, valid_d;
  logic          errv_q, errv_d;
  logic [1:0]    errc_q, errc_d;
  logic          ovr_q, ovr_d;

  logic [4:0]    up_dec;
  logic [4:0]    lo_dec;
  logic [6:0]    value;
  logic          fire;
  logic          good_evt;

  assign in_pat = {bus.Seg7In_upper, bus.Seg7In_lower};

  // Decode always works on the registered pair, never the live input.
  assign up_dec = glyph_to_digit(pat_q[13:7]);
  assign lo_dec = glyph_to_digit(pat_q[6:0]);
  // 7 bits: 9*10+9 = 99 must not wrap before the range check.
  assign value  = ({3'b000, up_dec[3:0]} * 7'd10) + {3'b000, lo_dec[3:0]};

  // A saturated count means the last STABLE_CYCLES samples were identical;
  // comparing against last_q suppresses repeat reports of a held pair.
  assign fire   = (cnt_q == CNT_MAX) && (pat_q != last_q);

  always_comb begin
    pat_d    = in_pat;
    cnt_d    = cnt_q;
    last_d   = last_q;
    bit6_d   = bit6_q;
    valid_d  = valid_q;
    errv_d   = 1'b0;
    errc_d   = 2'b00;
    ovr_d    = ovr_q;
    good_evt = 1'b0;

    if (in_pat != pat_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (fire) begin
      if (!up_dec[4]) begin
        errv_d = 1'b1;
        errc_d = 2'b01;
        last_d = pat_q;
      end else if (!lo_dec[4]) begin
        errv_d = 1'b1;
        errc_d = 2'b10;
        last_d = pat_q;
      end else if (value > 7'd63) begin
        errv_d = 1'b1;
        errc_d = 2'b11;
        last_d = pat_q;
      end else begin
        good_evt = 1'b1;
      end
    end

    if (good_evt) begin
      if (!valid_q || bus.out_ready) begin
        bit6_d  = value[5:0];
        valid_d = 1'b1;
        last_d  = pat_q;
      end else begin
        // Leave last_q alone so the same pair fires again once the
        // pending result has been taken.
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= PAT_ZERO;
      last_q  <= PAT_ZERO;
      cnt_q   <= '0;
      bit6_q  <= '0;
      valid_q <= 1'b0;
      errv_q  <= 1'b0;
      errc_q  <= 2'b00;
      ovr_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      bit6_q  <= bit6_d;
      valid_q <= valid_d;
      errv_q  <= errv_d;
      errc_q  <= errc_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.Bit6Out   = bit6_q;
  assign bus.out_valid = valid_q;
  assign bus.err_valid = errv_q;
  assign bus.err_code  = errc_q;
  assign bus.overrun   = ovr_q;

endmodule
